// File: rtl/secuenciador_mux_dd.sv
// ---------------------------------------------------------------------------
// secuenciador_mux_dd
//
// Purpose:
//   Steps the 4-bit data-block selector (Selec_Mux_DD) through the block
//   sequence of one RTC access. One bus-transaction request is issued for
//   each selector value. The selector advances only after the transaction
//   generator acknowledges the current block.
//     write sequence : 0 (init), 1 (MS), 2 (cmd/transfer), 3..5 date, 6..8 time
//     read sequence  : IDX_LECTURA..ULTIMO_IDX (init and MS skipped)
//   While idle, the selector rests at IDX_REPOSO, which the enable decoder
//   maps to all enables low.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   inicio       in   start request, sampled only while idle
//   escritura    in   mode latched with inicio (1 = write, 0 = read)
//   ack_trans    in   single-cycle acknowledge: current block is finished
//   Selec_Mux_DD out  registered data-block selector
//   req_trans    out  one-cycle request for the selected block
//   ocupado      out  high whenever the sequencer is not idle
//   fin          out  one-cycle pulse: sequence completed
//   error_to     out  one-cycle pulse: acknowledge timeout, sequence aborted
// ---------------------------------------------------------------------------
module secuenciador_mux_dd #(
    parameter logic [3:0]  ULTIMO_IDX  = 4'd8,
    parameter logic [3:0]  IDX_LECTURA = 4'd2,
    parameter logic [3:0]  IDX_REPOSO  = 4'hF,
    parameter logic [15:0] TIMEOUT     = 16'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       escritura,
    input  logic       ack_trans,
    output logic [3:0] Selec_Mux_DD,
    output logic       req_trans,
    output logic       ocupado,
    output logic       fin,
    output logic       error_to
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SOLICITA = 2'd1,
        ESPERA   = 2'd2,
        FIN      = 2'd3
    } estado_t;

    estado_t     r_estado;
    logic [3:0]  r_sel;
    logic [15:0] r_cnt;
    logic        r_modo_esc;
    logic        r_error_to;

    // First selector value of the running sequence, taken from the latched
    // mode so that later changes on escritura have no effect.
    logic [3:0]  w_idx_inicio;
    logic        w_avanza;
    logic        w_timeout;

    assign w_idx_inicio = r_modo_esc ? 4'd0 : IDX_LECTURA;

    // The selector steps only while it is inside the sequence window and
    // below the last block. This keeps it from wrapping. Any other value
    // closes the sequence instead of stepping.
    assign w_avanza  = (r_sel >= w_idx_inicio) && (r_sel < ULTIMO_IDX);
    assign w_timeout = (r_cnt == (TIMEOUT - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= REPOSO;
            r_sel      <= IDX_REPOSO;
            r_cnt      <= 16'd0;
            r_modo_esc <= 1'b0;
            r_error_to <= 1'b0;
        end else begin
            r_error_to <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_modo_esc <= escritura;
                        r_sel      <= escritura ? 4'd0 : IDX_LECTURA;
                        r_estado   <= SOLICITA;
                    end
                end

                // Single request cycle. Any acknowledge seen here belongs to
                // a previous transaction and is ignored.
                SOLICITA: begin
                    r_cnt    <= 16'd0;
                    r_estado <= ESPERA;
                end

                ESPERA: begin
                    r_cnt <= r_cnt + 16'd1;
                    // An acknowledge takes priority over a timeout that
                    // expires in the same cycle.
                    if (ack_trans) begin
                        if (w_avanza) begin
                            r_sel    <= r_sel + 4'd1;
                            r_estado <= SOLICITA;
                        end else begin
                            r_estado <= FIN;
                        end
                    end else if (w_timeout) begin
                        r_error_to <= 1'b1;
                        r_sel      <= IDX_REPOSO;
                        r_estado   <= REPOSO;
                    end
                end

                FIN: begin
                    r_sel    <= IDX_REPOSO;
                    r_estado <= REPOSO;
                end

                default: begin
                    r_sel    <= IDX_REPOSO;
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    // Outputs are decoded from registered state only, so they carry no
    // combinational path from the inputs.
    assign Selec_Mux_DD = r_sel;
    assign req_trans    = (r_estado == SOLICITA);
    assign ocupado      = (r_estado != REPOSO);
    assign fin          = (r_estado == FIN);
    assign error_to     = r_error_to;

endmodule

// File: tb/tb_secuenciador_mux_dd.sv
module tb_secuenciador_mux_dd;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       escritura = 1'b0;
    logic       ack_trans = 1'b0;
    logic [3:0] Selec_Mux_DD;
    logic       req_trans, ocupado, fin, error_to;

    int n_checks = 0;
    int n_errors = 0;

    // kind: 0 = request, 1 = fin, 2 = timeout error
    typedef struct {
        int         kind;
        logic [3:0] sel;
    } exp_t;
    exp_t q[$];

    secuenciador_mux_dd #(.TIMEOUT(16'd16)) dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .escritura    (escritura),
        .ack_trans    (ack_trans),
        .Selec_Mux_DD (Selec_Mux_DD),
        .req_trans    (req_trans),
        .ocupado      (ocupado),
        .fin          (fin),
        .error_to     (error_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each output event pops the next expected event.
    task automatic pop_cmp(input int kind, input string name);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected event, sel %0d", name, Selec_Mux_DD);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.sel != Selec_Mux_DD) begin
                n_errors++;
                $display("FAIL %s: got kind %0d sel %0d expected kind %0d sel %0d",
                         name, kind, Selec_Mux_DD, e.kind, e.sel);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (req_trans) pop_cmp(0, "req");
            if (fin)       pop_cmp(1, "fin");
            if (error_to)  pop_cmp(2, "error_to");
        end
    end

    // Reference model: a sequence is the list of block indices from the start
    // index up to 8. It ends with fin, or is cut short by a timeout or a reset.
    task automatic push_expected(input bit w, input int abort_blk, input int rst_blk);
        int start = w ? 0 : 2;
        for (int b = start; b <= 8; b++) begin
            q.push_back('{0, 4'(b)});
            if (b == abort_blk) begin
                q.push_back('{2, 4'hF});
                return;
            end
            if (b == rst_blk) return;
        end
        q.push_back('{1, 4'd8});
    endtask

    task automatic run_seq(input bit w, input int abort_blk, input int rst_blk);
        int start = w ? 0 : 2;
        int n;
        push_expected(w, abort_blk, rst_blk);
        escritura = w;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        escritura = 1'($urandom);
        chk("latency_req", int'(req_trans), 1);
        for (int b = start; b <= 8; b++) begin
            if (!req_trans) begin
                chk("req_present", 0, 1);
                return;
            end
            // An acknowledge during the request cycle must be ignored.
            ack_trans = 1'($urandom);
            step();
            ack_trans = 1'b0;
            if (b == abort_blk) begin
                n = 1;
                while (!error_to && n < 40) begin
                    step();
                    n++;
                end
                chk("timeout_cycles", n, 17);
                chk("to_sel", int'(Selec_Mux_DD), 15);
                chk("to_ocupado", int'(ocupado), 0);
                chk("to_fin", int'(fin), 0);
                step();
                return;
            end
            if (b == rst_blk) begin
                chk("pre_rst_sel", int'(Selec_Mux_DD), b);
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("rst_sel", int'(Selec_Mux_DD), 15);
                chk("rst_ocupado", int'(ocupado), 0);
                chk("rst_fin", int'(fin), 0);
                chk("rst_err", int'(error_to), 0);
                step();
                chk("rst_fin2", int'(fin), 0);
                chk("rst_err2", int'(error_to), 0);
                return;
            end
            repeat ($urandom_range(0, 4)) begin
                inicio = 1'($urandom);  // must not restart
                step();
                inicio = 1'b0;
            end
            chk("esp_sel", int'(Selec_Mux_DD), b);
            ack_trans = 1'b1;
            step();
            ack_trans = 1'b0;
        end
        chk("fin_pulse", int'(fin), 1);
        chk("fin_sel", int'(Selec_Mux_DD), 8);
        step();
        chk("post_fin", int'(fin), 0);
        chk("post_ocupado", int'(ocupado), 0);
        chk("post_sel", int'(Selec_Mux_DD), 15);
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("idle_sel", int'(Selec_Mux_DD), 15);
        chk("idle_req", int'(req_trans), 0);
        chk("idle_ocupado", int'(ocupado), 0);
        chk("idle_fin", int'(fin), 0);
        chk("idle_err", int'(error_to), 0);

        run_seq(1'b1, -1, -1);   // full write sequence
        step();
        run_seq(1'b0, -1, -1);   // full read sequence
        step();
        run_seq(1'b1, 0, -1);    // no ack after the first request
        run_seq(1'b0, 2, -1);
        run_seq(1'b1, -1, 6);    // reset while selector = 6 in ESPERA
        for (int i = 0; i < 10; i++) begin
            bit w = 1'($urandom);
            int ab = -1;
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(w ? 0 : 2, 8);
            run_seq(w, ab, -1);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
